// File: rtl/mips_reg_dump_if.sv
// ---------------------------------------------------------------------------
// mips_reg_dump_if
//
// Purpose: bundles the two buses of the register-dump engine into one
// interface: the register-file read port (strobe, address, returned data)
// and the outgoing valid/ready word stream (valid, ready, index, data, last).
//
// Signal summary (direction as seen by the dump engine, modport master):
//   rd_en_o       out  register-file read strobe
//   rd_addr_o     out  register-file read address (5 bits)
//   rd_data_i     in   read data, valid one cycle after rd_en_o
//   dump_valid_o  out  output word valid
//   dump_ready_i  in   downstream accept
//   dump_idx_o    out  register index of the current word (5 bits)
//   dump_data_o   out  register value of the current word
//   dump_last_o   out  current word is the final one of the dump
//
// Modports:
//   master  the dump engine
//   slave   the register file plus the downstream consumer
// ---------------------------------------------------------------------------
interface mips_reg_dump_if #(
    parameter int DATA_W = 32
);

    logic              rd_en_o;
    logic [4:0]        rd_addr_o;
    logic [DATA_W-1:0] rd_data_i;
    logic              dump_valid_o;
    logic              dump_ready_i;
    logic [4:0]        dump_idx_o;
    logic [DATA_W-1:0] dump_data_o;
    logic              dump_last_o;

    modport master (
        output rd_en_o,
        output rd_addr_o,
        input  rd_data_i,
        output dump_valid_o,
        input  dump_ready_i,
        output dump_idx_o,
        output dump_data_o,
        output dump_last_o
    );

    modport slave (
        input  rd_en_o,
        input  rd_addr_o,
        output rd_data_i,
        input  dump_valid_o,
        output dump_ready_i,
        input  dump_idx_o,
        input  dump_data_o,
        input  dump_last_o
    );

endinterface

// File: rtl/mips_reg_dump.sv
// ---------------------------------------------------------------------------
// mips_reg_dump
//
// Purpose: when the CPU halts (rising edge of halted_i) or on a manual
// start_i pulse, walk the register file from the first index up to
// NUM_REGS-1, reading one entry at a time and presenting each value as a
// word on a valid/ready stream. A one-cycle done_o pulse follows the
// acceptance of the final word.
//
// Per word the engine spends one cycle in READ (read strobe), one in LATCH
// (capture returned data), and at least one in SEND (waiting for ready),
// so the peak rate is one word every three cycles.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   halted_i   in   CPU halted flag; 0->1 transition starts a dump
//   start_i    in   single-cycle manual dump trigger
//   bus        --   mips_reg_dump_if.master: read port + output stream
//   busy_o     out  high whenever the engine is not IDLE
//   done_o     out  one-cycle pulse after the final word is accepted
//
// Parameters:
//   NUM_REGS   number of register-file entries dumped (2..32)
//   DATA_W     register data width (must match the interface DATA_W)
//
// Configuration macro:
//   REG_DUMP_SKIP_ZERO_EN  when defined, R0 is neither read nor sent and the
//                          dump starts at index 1 (NUM_REGS-1 words);
//                          otherwise it starts at index 0 (NUM_REGS words).
// ---------------------------------------------------------------------------
module mips_reg_dump #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            halted_i,
    input  logic            start_i,
    mips_reg_dump_if.master bus,
    output logic            busy_o,
    output logic            done_o
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        DONE
    } state_e;

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam logic [4:0] FIRST_IDX = 5'd1;
`else
    localparam logic [4:0] FIRST_IDX = 5'd0;
`endif

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_e            state_q, state_d;
    logic [4:0]        index_q, index_d;
    logic              halted_q;
    logic [4:0]        idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    logic              rd_en_q, rd_en_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              halted_rise;
    logic              trigger;

    // halted_q resets to 0, so a halted_i already high at reset release is
    // seen as a rising edge on the first clock after release.
    assign halted_rise = halted_i & ~halted_q;

    // Both trigger sources collapse into one request; they are only looked
    // at in IDLE, so anything arriving mid-dump is dropped rather than queued.
    assign trigger = halted_rise | start_i;

    // Next-state and datapath logic.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        idx_d   = idx_q;
        data_d  = data_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    index_d = FIRST_IDX;
                    state_d = READ;
                end
            end

            READ: begin
                state_d = LATCH;
            end

            LATCH: begin
                // Read data returns one cycle after the strobe, i.e. now.
                data_d  = bus.rd_data_i;
                idx_d   = index_q;
                last_d  = (index_q == LAST_IDX);
                state_d = SEND;
            end

            SEND: begin
                // valid is high for the whole of SEND, so ready alone marks
                // the handshake edge.
                if (bus.dump_ready_i) begin
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = READ;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered copies of "which state are we entering", so
    // they line up exactly with the state register and never glitch.
    always_comb begin
        rd_en_d = (state_d == READ);
        valid_d = (state_d == SEND);
        done_d  = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            index_q  <= 5'd0;
            halted_q <= 1'b0;
            idx_q    <= 5'd0;
            data_q   <= '0;
            last_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            halted_q <= halted_i;
            idx_q    <= idx_d;
            data_q   <= data_d;
            last_q   <= last_d;
            rd_en_q  <= rd_en_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.rd_en_o      = rd_en_q;
    assign bus.rd_addr_o    = index_q;
    assign bus.dump_valid_o = valid_q;
    assign bus.dump_idx_o   = idx_q;
    assign bus.dump_data_o  = data_q;
    assign bus.dump_last_o  = last_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;

    // A stalled word must stay put until it is taken.
    a_hold_while_stalled : assert property (
        @(posedge clk) disable iff (!rst_n)
        (valid_q && !bus.dump_ready_i) |=>
            (valid_q && $stable(data_q) && $stable(idx_q) && $stable(last_q))
    );

    // The read strobe never lasts more than one cycle.
    a_single_read : assert property (
        @(posedge clk) disable iff (!rst_n)
        rd_en_q |=> !rd_en_q
    );

    // The index register never runs past the final entry.
    a_no_wrap : assert property (
        @(posedge clk) disable iff (!rst_n)
        index_q <= LAST_IDX
    );

endmodule

// File: tb/tb_mips_reg_dump.sv
// ---------------------------------------------------------------------------
// tb_mips_reg_dump
//
// Purpose: directed self-checking bench for mips_reg_dump. A small
// register-file model answers read strobes one cycle later; each scenario
// task triggers a dump, records every accepted word, and compares the
// recorded stream against hand-computed expectations.
//
// Build with REG_DUMP_SKIP_ZERO_EN defined to check the skip-R0 variant.
// ---------------------------------------------------------------------------
module tb_mips_reg_dump;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;

`ifdef REG_DUMP_SKIP_ZERO_EN
    localparam int FIRST_IDX = 1;
`else
    localparam int FIRST_IDX = 0;
`endif

    localparam int NWORDS  = NUM_REGS - FIRST_IDX;
    localparam int MAXCYC  = 800;

    logic clk;
    logic rst_n;
    logic halted_i;
    logic start_i;
    logic busy_o;
    logic done_o;

    mips_reg_dump_if #(.DATA_W(DATA_W)) bus ();

    mips_reg_dump #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .halted_i (halted_i),
        .start_i  (start_i),
        .bus      (bus),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    int checks = 0;
    int errors = 0;

    // Results of the most recent collect_dump call.
    int          wordCount;
    int          wIdx  [0:63];
    logic [31:0] wData [0:63];
    logic        wLast [0:63];
    int          wCyc  [0:63];
    int          doneCycles;
    int          rdEnCount;
    int          firstRdEnCyc;
    int          firstValidCyc;
    int          stableErr;
    int          timedOut;

    logic [15:0] lfsr = 16'hACE1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Preloaded register contents; every other entry holds 0.
    function automatic logic [31:0] reg_value(input int r);
        case (r)
            1:       reg_value = 32'd10;
            2:       reg_value = 32'd15;
            3:       reg_value = 32'd5;
            4:       reg_value = 32'd50;
            5:       reg_value = 32'd55;
            6:       reg_value = 32'd42;
            default: reg_value = 32'd0;
        endcase
    endfunction

    // Register file: data appears one cycle after the strobe; garbage
    // otherwise so a mistimed capture is visible.
    always @(posedge clk) begin
        if (bus.rd_en_o)
            bus.rd_data_i <= reg_value(int'(bus.rd_addr_o));
        else
            bus.rd_data_i <= 32'hDEAD_BEEF;
    end

    // Runs one dump whose trigger the caller has just driven at a negedge.
    // Samples at negedges, drives ready (1 always, or LFSR-random), records
    // accepted words, and stops three cycles after the first done pulse.
    task automatic collect_dump(input int readyMode, input int midStartCyc);
        logic        holdPrev;
        logic [4:0]  heldIdx;
        logic [31:0] heldData;
        logic        heldLast;
        int          doneCyc;
        bit          finished;
        wordCount     = 0;
        doneCycles    = 0;
        rdEnCount     = 0;
        firstRdEnCyc  = -1;
        firstValidCyc = -1;
        stableErr     = 0;
        timedOut      = 0;
        holdPrev      = 1'b0;
        heldIdx       = '0;
        heldData      = '0;
        heldLast      = 1'b0;
        doneCyc       = -1;
        finished      = 1'b0;
        for (int cyc = 1; cyc <= MAXCYC; cyc++) begin
            @(negedge clk);
            start_i = (cyc == midStartCyc);
            if (bus.rd_en_o) begin
                rdEnCount++;
                if (firstRdEnCyc < 0) firstRdEnCyc = cyc;
            end
            if (done_o) begin
                doneCycles++;
                if (doneCyc < 0) doneCyc = cyc;
            end
            if (holdPrev) begin
                if (!bus.dump_valid_o || bus.dump_idx_o !== heldIdx ||
                    bus.dump_data_o !== heldData || bus.dump_last_o !== heldLast)
                    stableErr++;
            end
            if (readyMode == 0) begin
                bus.dump_ready_i = 1'b1;
            end else begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                bus.dump_ready_i = lfsr[0];
            end
            holdPrev = 1'b0;
            if (bus.dump_valid_o) begin
                if (firstValidCyc < 0) firstValidCyc = cyc;
                if (bus.dump_ready_i) begin
                    if (wordCount < 64) begin
                        wIdx[wordCount]  = int'(bus.dump_idx_o);
                        wData[wordCount] = bus.dump_data_o;
                        wLast[wordCount] = bus.dump_last_o;
                        wCyc[wordCount]  = cyc;
                    end
                    wordCount++;
                end else begin
                    holdPrev = 1'b1;
                    heldIdx  = bus.dump_idx_o;
                    heldData = bus.dump_data_o;
                    heldLast = bus.dump_last_o;
                end
            end
            if (doneCyc >= 0 && cyc >= doneCyc + 3) begin
                finished = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        bus.dump_ready_i = 1'b0;
        if (!finished) timedOut = 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        halted_i = 1'b0;
        start_i = 1'b0;
        bus.dump_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rd_en_o !== 1'b0 || bus.dump_valid_o !== 1'b0 || bus.dump_last_o !== 1'b0 ||
            busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got rd_en=%b valid=%b last=%b busy=%b done=%b required all 0",
                     bus.rd_en_o, bus.dump_valid_o, bus.dump_last_o, busy_o, done_o);
        end
        checks++;
        if (bus.rd_addr_o !== 5'd0 || bus.dump_idx_o !== 5'd0 || bus.dump_data_o !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: got addr=%0d idx=%0d data=%h required 0",
                     bus.rd_addr_o, bus.dump_idx_o, bus.dump_data_o);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: got busy=%b required 0", busy_o);
        end
    endtask

    task automatic test_halted_dump;
        halted_i = 1'b1;
        collect_dump(0, 0);
        checks++;
        if (timedOut !== 0) begin
            errors++;
            $display("[TB] FAIL halted_timeout: got timedOut=%0d required 0", timedOut);
        end
        checks++;
        if (wordCount !== NWORDS) begin
            errors++;
            $display("[TB] FAIL halted_count: got %0d words required %0d", wordCount, NWORDS);
        end
        for (int i = 0; i < NWORDS && i < wordCount; i++) begin
            checks++;
            if (wIdx[i] !== FIRST_IDX + i) begin
                errors++;
                $display("[TB] FAIL halted_idx[%0d]: got %0d required %0d", i, wIdx[i], FIRST_IDX + i);
            end
            checks++;
            if (wData[i] !== reg_value(FIRST_IDX + i)) begin
                errors++;
                $display("[TB] FAIL halted_data[%0d]: got %h required %h", i, wData[i], reg_value(FIRST_IDX + i));
            end
            checks++;
            if (wLast[i] !== (i == NWORDS - 1)) begin
                errors++;
                $display("[TB] FAIL halted_last[%0d]: got %b required %b", i, wLast[i], (i == NWORDS - 1));
            end
            if (i > 0) begin
                checks++;
                if (wCyc[i] - wCyc[i-1] !== 3) begin
                    errors++;
                    $display("[TB] FAIL halted_spacing[%0d]: got %0d cycles required 3", i, wCyc[i] - wCyc[i-1]);
                end
            end
        end
        checks++;
        if (firstRdEnCyc !== 1 || firstValidCyc !== 3) begin
            errors++;
            $display("[TB] FAIL halted_latency: got rd_en cycle %0d valid cycle %0d required 1 and 3",
                     firstRdEnCyc, firstValidCyc);
        end
        checks++;
        if (rdEnCount !== NWORDS) begin
            errors++;
            $display("[TB] FAIL halted_reads: got %0d strobes required %0d", rdEnCount, NWORDS);
        end
        checks++;
        if (doneCycles !== 1) begin
            errors++;
            $display("[TB] FAIL halted_done: got %0d done cycles required 1", doneCycles);
        end
    endtask

    task automatic test_halted_hold;
        int busyCount;
        busyCount = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy_o) busyCount++;
        end
        checks++;
        if (busyCount !== 0) begin
            errors++;
            $display("[TB] FAIL hold_no_redump: got %0d busy cycles required 0", busyCount);
        end
        halted_i = 1'b0;
        @(negedge clk);
        halted_i = 1'b1;
        collect_dump(0, 0);
        checks++;
        if (wordCount !== NWORDS || doneCycles !== 1 || timedOut !== 0) begin
            errors++;
            $display("[TB] FAIL hold_second_dump: got %0d words %0d done required %0d words 1 done",
                     wordCount, doneCycles, NWORDS);
        end
    endtask

    task automatic test_backpressure;
        halted_i = 1'b0;
        @(negedge clk);
        start_i = 1'b1;
        collect_dump(1, 0);
        checks++;
        if (wordCount !== NWORDS || timedOut !== 0) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d words timedOut=%0d required %0d", wordCount, timedOut, NWORDS);
        end
        for (int i = 0; i < NWORDS && i < wordCount; i++) begin
            checks++;
            if (wIdx[i] !== FIRST_IDX + i || wData[i] !== reg_value(FIRST_IDX + i) ||
                wLast[i] !== (i == NWORDS - 1)) begin
                errors++;
                $display("[TB] FAIL bp_word[%0d]: got idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                         i, wIdx[i], wData[i], wLast[i], FIRST_IDX + i, reg_value(FIRST_IDX + i), (i == NWORDS - 1));
            end
        end
        checks++;
        if (stableErr !== 0) begin
            errors++;
            $display("[TB] FAIL bp_stable: got %0d unstable stalls required 0", stableErr);
        end
        checks++;
        if (doneCycles !== 1) begin
            errors++;
            $display("[TB] FAIL bp_done: got %0d done cycles required 1", doneCycles);
        end
    endtask

    task automatic test_simultaneous;
        int busyCount;
        halted_i = 1'b1;
        start_i = 1'b1;
        collect_dump(0, 20);
        checks++;
        if (wordCount !== NWORDS || doneCycles !== 1 || timedOut !== 0) begin
            errors++;
            $display("[TB] FAIL simul_one_dump: got %0d words %0d done required %0d words 1 done",
                     wordCount, doneCycles, NWORDS);
        end
        busyCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy_o) busyCount++;
        end
        checks++;
        if (busyCount !== 0) begin
            errors++;
            $display("[TB] FAIL simul_no_queue: got %0d busy cycles required 0", busyCount);
        end
    endtask

    task automatic test_reset_abort;
        bit found;
        int doneSeen;
        halted_i = 1'b0;
        repeat (2) @(negedge clk);
        start_i = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            start_i = 1'b0;
            bus.dump_ready_i = 1'b1;
            if (bus.dump_valid_o && bus.dump_idx_o == 5'd5) begin
                bus.dump_ready_i = 1'b0;
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL abort_reach_idx5: got no word 5 required word 5 in SEND");
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.dump_valid_o !== 1'b0 || bus.dump_idx_o !== 5'd0 || bus.dump_data_o !== 32'd0 ||
            bus.dump_last_o !== 1'b0 || busy_o !== 1'b0 || bus.rd_en_o !== 1'b0 ||
            bus.rd_addr_o !== 5'd0 || done_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got valid=%b idx=%0d data=%h busy=%b addr=%0d required all 0",
                     bus.dump_valid_o, bus.dump_idx_o, bus.dump_data_o, busy_o, bus.rd_addr_o);
        end
        doneSeen = 0;
        repeat (2) begin
            @(negedge clk);
            if (done_o) doneSeen++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (done_o || busy_o) doneSeen++;
        end
        checks++;
        if (doneSeen !== 0) begin
            errors++;
            $display("[TB] FAIL abort_no_done: got %0d done/busy cycles required 0", doneSeen);
        end
        start_i = 1'b1;
        collect_dump(0, 0);
        checks++;
        if (wordCount !== NWORDS || wIdx[0] !== FIRST_IDX || doneCycles !== 1) begin
            errors++;
            $display("[TB] FAIL abort_restart: got %0d words first idx %0d required %0d words first idx %0d",
                     wordCount, wIdx[0], NWORDS, FIRST_IDX);
        end
    endtask

    task automatic test_reset_halted_high;
        @(negedge clk);
        rst_n = 1'b0;
        halted_i = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        collect_dump(0, 0);
        checks++;
        if (firstRdEnCyc !== 1 || firstValidCyc !== 3) begin
            errors++;
            $display("[TB] FAIL rel_latency: got rd_en cycle %0d valid cycle %0d required 1 and 3",
                     firstRdEnCyc, firstValidCyc);
        end
        checks++;
        if (wordCount !== NWORDS || doneCycles !== 1 || timedOut !== 0) begin
            errors++;
            $display("[TB] FAIL rel_dump: got %0d words %0d done required %0d words 1 done",
                     wordCount, doneCycles, NWORDS);
        end
        halted_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_halted_dump();
        test_halted_hold();
        test_backpressure();
        test_simultaneous();
        test_reset_abort();
        test_reset_halted_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mips_reg_dump.md
MIPS_REG_DUMP -- requirements
Module: mips_reg_dump

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32; number of register-file entries dumped (2..32).
REQ-002 SHALL have parameter DATA_W, default 32; register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port halted_i  input  1  CPU halted flag; a 0->1 transition triggers a dump.
REQ-006 SHALL have port start_i  input  1  single-cycle manual dump trigger.
REQ-007 SHALL have port rd_en_o  output  1  register-file read strobe.
REQ-008 SHALL have port rd_addr_o  output  5  register-file read address.
REQ-009 SHALL have port rd_data_i  input  DATA_W  read data, valid one cycle after rd_en_o.
REQ-010 SHALL have port dump_valid_o  output  1  output word valid.
REQ-011 SHALL have port dump_ready_i  input  1  downstream accept.
REQ-012 SHALL have port dump_idx_o  output  5  register index of current word.
REQ-013 SHALL have port dump_data_o  output  DATA_W  register value.
REQ-014 SHALL have port dump_last_o  output  1  current word is the final one.
REQ-015 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done_o  output  1  one-cycle pulse after final word is accepted.

Function
REQ-017 SHALL implement FSM states IDLE, READ, LATCH, SEND, DONE.
REQ-018 SHALL register halted_i and detect a rising edge as halted_i=1 with previous sample=0.
REQ-019 IDLE: on trigger (halted rising edge or start_i), SHALL load index with first index and go to READ; simultaneous triggers count as one dump.
REQ-020 Triggers outside IDLE SHALL be ignored (not queued).
REQ-021 READ: SHALL assert rd_en_o for exactly one cycle with rd_addr_o = index; next state LATCH.
REQ-022 LATCH: SHALL capture rd_data_i into dump_data_o and index into dump_idx_o; next state SEND.
REQ-023 SEND: SHALL hold dump_valid_o=1 with dump_data_o, dump_idx_o and dump_last_o stable until dump_valid_o and dump_ready_i are high on the same edge.
REQ-024 On acceptance of a non-last word, SHALL increment index and go to READ; on the last word, SHALL go to DONE.
REQ-025 dump_last_o SHALL be 1 only when index = NUM_REGS-1.
REQ-026 DONE: SHALL assert done_o for exactly one cycle, then return to IDLE.
REQ-027 Latency SHALL be: dump_valid_o first high in the 3rd cycle after the trigger-sampling edge; each subsequent word valid 2 cycles after the previous accept (peak rate 1 word per 3 cycles).
REQ-028 dump_ready_i held high before valid SHALL NOT cause acceptance outside SEND.
REQ-029 rd_en_o SHALL be 0 outside READ; rd_addr_o SHALL equal index at all times.
REQ-030 Index SHALL NOT wrap; the dump ends at NUM_REGS-1.

Reset
REQ-031 rst_n=0 SHALL asynchronously force state IDLE, index 0, halted sample 0, and all outputs 0 (dump_data_o 0, dump_idx_o 0).
REQ-032 Reset asserted mid-dump SHALL abort it with no done_o pulse; after release, a fresh trigger SHALL restart from the first index.
REQ-033 If halted_i is already 1 when rst_n releases, SHALL treat it as a rising edge and dump on the first cycle after reset release.

Configuration
REQ-034 With macro REG_DUMP_SKIP_ZERO_EN defined, first index SHALL be 1 (R0 not read or sent; NUM_REGS-1 words per dump).
REQ-035 Without REG_DUMP_SKIP_ZERO_EN, first index SHALL be 0 (NUM_REGS words per dump).

Verification
REQ-036 Reset, preload R1=10,R2=15,R3=5,R4=50,R5=55,R6=42, ready=1, pulse halted_i 0->1 -> 32 words idx 0..31 with those values, others 0, last only on idx 31, one done_o pulse.
REQ-037 Same preload, ready toggling 1-0-1 pseudo-randomly -> identical sequence; data/idx stable while valid and ready low; no word duplicated or dropped.
REQ-038 start_i pulsed and halted_i rising on the same cycle -> exactly one dump of 32 words; start_i pulsed mid-dump -> ignored.
REQ-039 rst_n low while idx 5 is in SEND -> all outputs 0 immediately, no done_o; next start_i -> dump restarts at idx 0.
REQ-040 With REG_DUMP_SKIP_ZERO_EN, halted rising -> 31 words idx 1..31, R1=10 first, last on idx 31.
REQ-041 halted_i held 1 for 100 cycles after a completed dump -> no second dump; drop to 0 then 1 -> second dump.
